// File: rtl/serial_subtractor_if.sv
// Operand/result bus for the bit-serial subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, A, B, Bin,
        input  busy, done, Diff, Bout
`ifdef SERIAL_SUB_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, A, B, Bin,
        output busy, done, Diff, Bout
`ifdef SERIAL_SUB_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - Bin, LSB first, one full-subtractor cell, start/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state,  w_state_nxt;
    logic [WIDTH-1:0] r_a,      w_a_nxt;
    logic [WIDTH-1:0] r_b,      w_b_nxt;
    logic             r_br,     w_br_nxt;
    logic [WIDTH-1:0] r_work,   w_work_nxt;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
    logic             r_busy,   w_busy_nxt;
    logic             r_done,   w_done_nxt;
    logic [WIDTH-1:0] r_diff,   w_diff_nxt;
    logic             r_bout,   w_bout_nxt;
`ifdef SERIAL_SUB_OVF_EN
    logic             r_msb_br, w_msb_br_nxt;
    logic             r_ovf,    w_ovf_nxt;
`endif

    logic w_d;
    logic w_br_cell;
    logic w_last;

    // Full-subtractor cell on the current LSBs
    assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_cell = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_br_nxt    = r_br;
        w_work_nxt  = r_work;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_diff_nxt  = r_diff;
        w_bout_nxt  = r_bout;
`ifdef SERIAL_SUB_OVF_EN
        w_msb_br_nxt = r_msb_br;
        w_ovf_nxt    = r_ovf;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_a_nxt     = bus.A;
                    w_b_nxt     = bus.B;
                    w_br_nxt    = bus.Bin;
                    w_work_nxt  = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_work_nxt = {w_d, r_work[WIDTH-1:1]};
                w_a_nxt    = r_a >> 1;
                w_b_nxt    = r_b >> 1;
                w_br_nxt   = w_br_cell;
                w_cnt_nxt  = r_cnt + CNT_W'(1);
`ifdef SERIAL_SUB_OVF_EN
                if (w_last) begin
                    w_msb_br_nxt = r_br;
                end
`endif
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_diff_nxt  = r_work;
                w_bout_nxt  = r_br;
`ifdef SERIAL_SUB_OVF_EN
                w_ovf_nxt   = r_msb_br ^ r_br;
`endif
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // busy stays up through the cycle in which done is presented
        w_busy_nxt = (w_state_nxt != S_IDLE) || (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_br     <= 1'b0;
            r_work   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_msb_br <= 1'b0;
            r_ovf    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_br     <= w_br_nxt;
            r_work   <= w_work_nxt;
            r_cnt    <= w_cnt_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_diff   <= w_diff_nxt;
            r_bout   <= w_bout_nxt;
`ifdef SERIAL_SUB_OVF_EN
            r_msb_br <= w_msb_br_nxt;
            r_ovf    <= w_ovf_nxt;
`endif
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.Diff = r_diff;
    assign bus.Bout = r_bout;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf  = r_ovf;
`endif

endmodule
